// File: rtl/id_dispatch_queue.sv
// id_dispatch_queue: decode-to-dispatch FIFO with redirect flush, fetch freeze and serializing-instruction drain/bubble control
//   CLK, RESET       clock, synchronous active-high reset
//   enq_*            decoder-side valid/ready bundle input
//   deq_*            dispatch-side valid/ready head bundle output (head read straight from storage)
//   flush_IN         branch/jump redirect, empties the queue
//   drained_IN       backend idle, lets a serializing head dispatch
//   SYS              one-cycle pulse after a notifying serializing dispatch
//   WANT_FREEZE      fetch/decode hold request
//   count_OUT        occupancy
module id_dispatch_queue #(
  parameter int DEPTH = 8,
  parameter int PAYLOAD_W = 64,
  parameter int FREEZE_MARGIN = 1,
  parameter int BUBBLE_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   enq_valid_IN,
  output logic                   enq_ready_OUT,
  input  logic [31:0]            enq_instr_IN,
  input  logic [31:0]            enq_pc_IN,
  input  logic [PAYLOAD_W-1:0]   enq_payload_IN,
  input  logic                   enq_serialize_IN,
  input  logic                   enq_notify_IN,
  output logic                   deq_valid_OUT,
  input  logic                   deq_ready_IN,
  output logic [31:0]            deq_instr_OUT,
  output logic [31:0]            deq_pc_OUT,
  output logic [PAYLOAD_W-1:0]   deq_payload_OUT,
  output logic                   deq_serialize_OUT,
  input  logic                   flush_IN,
  input  logic                   drained_IN,
  output logic                   SYS,
  output logic                   WANT_FREEZE,
  output logic [$clog2(DEPTH):0] count_OUT
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BUBBLE_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] FREEZE_AT = CW'(DEPTH - FREEZE_MARGIN);
  localparam logic [BW-1:0] BUB_LOAD = BW'(BUBBLE_CYCLES);
  typedef enum logic [1:0] {NORMAL, WAIT_DRAIN, BUBBLE} state_e;
  state_e state_q;
  logic [BW-1:0] bub_q;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic sys_q;
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
  logic ser_mem [DEPTH];
  logic ntf_mem [DEPTH];
  logic not_empty, head_ser, head_ntf, enq_hs, deq_hs;
  assign not_empty = count_q != '0;
  assign head_ser = ser_mem[rd_q];
  assign head_ntf = ntf_mem[rd_q];
  assign enq_ready_OUT = count_q < FULL;
  // A serializing head is only offered once the backend reports drained.
  assign deq_valid_OUT = not_empty & ((state_q == NORMAL) ? (!head_ser | drained_IN) : ((state_q == WAIT_DRAIN) & drained_IN));
  assign enq_hs = enq_valid_IN & enq_ready_OUT & !flush_IN;
  assign deq_hs = deq_valid_OUT & deq_ready_IN;
  assign deq_instr_OUT = instr_mem[rd_q];
  assign deq_pc_OUT = pc_mem[rd_q];
  assign deq_payload_OUT = payload_mem[rd_q];
  assign deq_serialize_OUT = head_ser;
  assign SYS = sys_q;
  assign WANT_FREEZE = (count_q >= FREEZE_AT) | (state_q != NORMAL);
  assign count_OUT = count_q;
  always_comb begin
    rd_d = flush_IN ? '0 : rd_q + PW'(deq_hs);
    wr_d = flush_IN ? '0 : wr_q + PW'(enq_hs);
    count_d = flush_IN ? '0 : count_q + CW'(enq_hs) - CW'(deq_hs);
  end
  always_ff @(posedge CLK) begin
    if (enq_hs) begin
      instr_mem[wr_q] <= enq_instr_IN;
      pc_mem[wr_q] <= enq_pc_IN;
      payload_mem[wr_q] <= enq_payload_IN;
      ser_mem[wr_q] <= enq_serialize_IN;
      ntf_mem[wr_q] <= enq_notify_IN;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= NORMAL;
      bub_q <= '0;
      sys_q <= 1'b0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      // A dispatch coinciding with a flush is kept but neither bubbles nor notifies.
      sys_q <= deq_hs & head_ser & head_ntf & !flush_IN;
      if (flush_IN) begin
        state_q <= NORMAL;
        bub_q <= '0;
      end else if (deq_hs & head_ser) begin
        state_q <= BUBBLE;
        bub_q <= BUB_LOAD;
      end else if (state_q == BUBBLE) begin
        bub_q <= bub_q - BW'(1);
        if (bub_q == BW'(1)) state_q <= NORMAL;
      end else if ((state_q == NORMAL) & not_empty & head_ser & !drained_IN) begin
        state_q <= WAIT_DRAIN;
      end
    end
  end
endmodule

// File: doc/id_dispatch_queue.md
Name: id_dispatch_queue

Overview:
- Parametrised decode-to-dispatch buffer between the ID decoder and the out-of-order rename/issue stage.
- Replaces the fixed single-entry ID output registers and the hard-coded syscall bubble counter with:
  - a DEPTH-entry FIFO of decoded instruction bundles;
  - branch-redirect flush;
  - an almost-full fetch freeze;
  - a serialization state machine that drains the backend before a syscall/LL/SC leaves the queue.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
PAYLOAD_W, 64, width of opaque decoded-control payload (ALU control, regs, mem flags, shamt)
FREEZE_MARGIN, 1, WANT_FREEZE asserts when count >= DEPTH - FREEZE_MARGIN; 0 <= FREEZE_MARGIN < DEPTH
BUBBLE_CYCLES, 2, dispatch-blocked cycles after a serializing instruction dequeues; >= 1

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
enq_valid_IN  in  1  decoder presents a bundle
enq_ready_OUT  out  1  queue accepts a bundle (count < DEPTH)
enq_instr_IN  in  32  raw instruction
enq_pc_IN  in  32  instruction PC
enq_payload_IN  in  PAYLOAD_W  decoded control bundle
enq_serialize_IN  in  1  instruction must dispatch alone into a drained backend (syscall, LL, SC)
enq_notify_IN  in  1  simulator must be told (syscall = 1, LL/SC = 0); ignored unless serialize = 1
deq_valid_OUT  out  1  head bundle offered to dispatch
deq_ready_IN  in  1  dispatch accepts head
deq_instr_OUT  out  32  head instruction
deq_pc_OUT  out  32  head PC
deq_payload_OUT  out  PAYLOAD_W  head payload
deq_serialize_OUT  out  1  head serialize flag
flush_IN  in  1  branch/jump redirect; discard all queued bundles
drained_IN  in  1  backend holds no uncommitted instructions
SYS  out  1  one-cycle pulse: notifying serializing instruction was dispatched
WANT_FREEZE  out  1  fetch/decode must hold
count_OUT  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer with rd_ptr/wr_ptr of clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; separate count register.
- Enqueue handshake: enq_valid_IN & enq_ready_OUT; enq_ready_OUT = (count < DEPTH), independent of deq_ready_IN (no same-cycle pass-through when full).
- Dequeue handshake: deq_valid_OUT & deq_ready_IN.
- deq_* data = entry at rd_ptr, driven combinationally from storage; undefined but stable when deq_valid_OUT = 0.
- Latency: an accepted bundle is visible at deq no earlier than the next cycle; there is no empty-queue bypass.
- Simultaneous enq+deq: count unchanged; both pointers advance.
- Serialization FSM:
  - States: NORMAL, WAIT_DRAIN, BUBBLE. Bubble counter is clog2(BUBBLE_CYCLES+1) bits.
  - NORMAL, head not serializing: deq_valid_OUT = (count != 0).
  - NORMAL, head serializing with drained_IN = 0: deq_valid_OUT = 0; next state WAIT_DRAIN.
  - NORMAL, head serializing with drained_IN = 1: deq_valid_OUT = 1. On handshake go to BUBBLE and load counter = BUBBLE_CYCLES.
  - WAIT_DRAIN: deq_valid_OUT = drained_IN. On handshake go to BUBBLE and load counter.
  - BUBBLE: deq_valid_OUT = 0; counter decrements each cycle; move to NORMAL in the cycle the counter reaches 1. Enqueue still allowed.
- SYS: registered. Equals 1 in the cycle after a dequeue handshake of an entry with serialize = 1 and notify = 1; otherwise 0.
- WANT_FREEZE = (count >= DEPTH - FREEZE_MARGIN) | (state != NORMAL), combinational from registers.
- Flush (flush_IN = 1), takes priority over everything:
  - next cycle count = 0, rd_ptr = wr_ptr = 0, state NORMAL, bubble counter 0;
  - same-cycle enqueue is discarded;
  - a same-cycle dequeue handshake still counts as dispatched, but does not enter BUBBLE and produces no SYS pulse.
- Reset (RESET = 1), overrides flush and every other input, including mid-WAIT_DRAIN or mid-BUBBLE:
  - count = 0, pointers = 0, state NORMAL, bubble counter 0;
  - SYS = 0, deq_valid_OUT = 0, enq_ready_OUT = 1, WANT_FREEZE = 0 (FREEZE_MARGIN < DEPTH), count_OUT = 0;
  - storage contents need not be cleared.
- Outputs while empty: deq_valid_OUT = 0; deq_ready_IN ignored.
- Outputs while full: enq_ready_OUT = 0; enq_valid_IN ignored.

Test Plan:
- Fill/drain, DEPTH = 8: enqueue 8 bundles PC 0x100..0x11C with deq_ready_IN = 0 -> count_OUT = 8, enq_ready_OUT = 0, WANT_FREEZE = 1 from count 7. A 9th enq_valid_IN is dropped. Drain -> PCs out in order 0x100..0x11C, then deq_valid_OUT = 0.
- Wrap and concurrency: steady enq+deq every cycle for 20 cycles starting at count 3 -> count_OUT stays 3; PC order preserved across pointer wrap.
- Syscall serialization: enqueue add, syscall (serialize = 1, notify = 1), add; drained_IN = 0 for 5 cycles after the first add dispatches -> syscall held, WANT_FREEZE = 1. Raise drained_IN -> syscall dispatches, SYS = 1 for exactly one cycle, next add blocked exactly 2 cycles.
- LL serialization: serialize = 1, notify = 0, drained_IN = 1 -> dispatched immediately, 2-cycle bubble, SYS stays 0.
- Flush: 5 entries queued plus enq_valid_IN asserted in the flush cycle -> next cycle count_OUT = 0, deq_valid_OUT = 0, enq_ready_OUT = 1. The flush-cycle bundle never appears at deq.
- Reset in WAIT_DRAIN with 4 entries queued: RESET = 1 for one cycle -> all outputs at reset values, state NORMAL. A subsequent enqueue dequeues normally.
